// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester handshake and register-file write bus; master = requesters/register_file side, slave = arbiter
interface rf_write_arbiter_if #(
  parameter int nreq = 3,
  parameter int reg_width = 32,
  parameter int addr_width = 5
);
  logic [nreq-1:0] req_valid;
  logic [nreq*addr_width-1:0] req_addr;
  logic [nreq*reg_width-1:0] req_data;
  logic [nreq-1:0] req_ready;
  logic write_en;
  logic [addr_width-1:0] addr_rd;
  logic [reg_width-1:0] rd;
  logic init_done;
  modport master (
    output req_valid, req_addr, req_data,
    input req_ready, write_en, addr_rd, rd, init_done
  );
  modport slave (
    input req_valid, req_addr, req_data,
    output req_ready, write_en, addr_rd, rd, init_done
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: clears x1..x(nregs-1) after reset, then round-robin arbitrates nreq writeback requesters onto the register-file write port; ports clk, rst (async high), bus (req_valid/addr/data in, req_ready/write_en/addr_rd/rd/init_done out)
module rf_write_arbiter #(
  parameter int nregs = 32,
  parameter int nreq = 3,
  parameter int reg_width = 32,
  parameter int addr_width = 5
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  localparam int pw = nreq > 1 ? $clog2(nreq) : 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [addr_width-1:0] cnt;
  logic [pw-1:0] ptr, gidx, idx;
  logic [nreq-1:0] grant;
  logic found;
  logic [addr_width-1:0] gaddr;
  logic [reg_width-1:0] gdata;
  always_comb begin
    grant = '0;
    gidx = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < nreq; k++) begin
      idx = pw'((int'(ptr) + k) % nreq);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        gidx = idx;
      end
    end
  end
  always_comb begin
    gaddr = '0;
    gdata = '0;
    for (int k = 0; k < nreq; k++) begin
      if (grant[k]) begin
        gaddr = bus.req_addr[k*addr_width +: addr_width];
        gdata = bus.req_data[k*reg_width +: reg_width];
      end
    end
  end
  assign bus.req_ready = (state == RUN) ? grant : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt <= addr_width'(1);
      ptr <= '0;
      bus.write_en <= 1'b0;
      bus.addr_rd <= '0;
      bus.rd <= '0;
      bus.init_done <= 1'b0;
    end else if (state == INIT) begin
      bus.write_en <= 1'b1;
      bus.addr_rd <= cnt;
      bus.rd <= '0;
      cnt <= cnt + 1'b1;
      if (cnt == addr_width'(nregs - 1)) begin
        state <= RUN;
        bus.init_done <= 1'b1;
      end
    end else begin
      // x0 requests complete the handshake but never reach the register file
      bus.write_en <= found && (gaddr != '0);
      if (found) ptr <= (int'(gidx) == nreq - 1) ? '0 : gidx + 1'b1;
      if (found && gaddr != '0) begin
        bus.addr_rd <= gaddr;
        bus.rd <= gdata;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized and directed checks of rf_write_arbiter against a round-robin reference model
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rf_write_arbiter_if bus ();
  rf_write_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  logic [31:0] rf [32];
  logic [31:0] mrf [32];
  logic [4:0] last_a;
  logic [31:0] last_d;
  bit hold_ok;
  logic [2:0] o_rdy;
  logic o_we;
  logic [4:0] o_a;
  logic [31:0] o_d;
  always_ff @(posedge clk) if (bus.write_en && bus.addr_rd != 5'd0) rf[bus.addr_rd] <= bus.rd;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  function automatic int model_grant(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction
  function automatic logic [2:0] onehot(input int g);
    return g < 0 ? 3'b000 : 3'(1 << g);
  endfunction
  task automatic model_step(input logic [2:0] v, input logic [2:0][4:0] a, input logic [2:0][31:0] d,
                            output logic [2:0] er, output logic ewe, output logic [4:0] ea, output logic [31:0] ed);
    int g;
    g = model_grant(v, ptr_m);
    er = onehot(g);
    if (g >= 0) ptr_m = (g + 1) % 3;
    if (g >= 0 && a[g] != 5'd0) begin
      ewe = 1'b1;
      last_a = a[g];
      last_d = d[g];
      mrf[a[g]] = d[g];
      hold_ok = 1'b1;
    end else begin
      ewe = 1'b0;
      if (g >= 0) hold_ok = 1'b0;
    end
    ea = last_a;
    ed = last_d;
  endtask
  task automatic step(input logic [2:0] v, input logic [2:0][4:0] a, input logic [2:0][31:0] d);
    bus.req_valid = v;
    bus.req_addr = a;
    bus.req_data = d;
    #1 o_rdy = bus.req_ready;
    @(posedge clk);
    #1;
    o_we = bus.write_en;
    o_a = bus.addr_rd;
    o_d = bus.rd;
  endtask
  task automatic sweep_from_reset(input string tag);
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus.write_en !== 1'b1 || bus.addr_rd !== 5'(k) || bus.rd !== 32'd0 || bus.init_done !== (k == 31)) begin
        fails++;
        $display("FAIL %s sweep edge %0d: we=%b addr=%0d rd=%h done=%b, required we=1 addr=%0d rd=0 done=%b",
                 tag, k, bus.write_en, bus.addr_rd, bus.rd, bus.init_done, k, k == 31);
      end
      tests++;
      if (bus.req_ready !== (k < 31 ? 3'b000 : 3'b001)) begin
        fails++;
        $display("FAIL %s ready edge %0d: got %b required %b", tag, k, bus.req_ready, k < 31 ? 3'b000 : 3'b001);
      end
    end
    bus.req_valid = '0;
    ptr_m = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    last_a = 5'd31;
    last_d = 32'd0;
    hold_ok = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.write_en !== 1'b0) begin
      fails++;
      $display("FAIL %s idle after sweep: we=%b required 0", tag, bus.write_en);
    end
    for (int i = 1; i < 32; i++) begin
      tests++;
      if (rf[i] !== 32'd0) begin
        fails++;
        $display("FAIL %s cleared x%0d: got %h required 0", tag, i, rf[i]);
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_addr = {5'd3, 5'd2, 5'd1};
    bus.req_data = {$urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.write_en, bus.addr_rd, bus.rd, bus.init_done, bus.req_ready} !== '0) begin
      fails++;
      $display("FAIL reset state: we=%b addr=%0d rd=%h done=%b ready=%b, required all 0",
               bus.write_en, bus.addr_rd, bus.rd, bus.init_done, bus.req_ready);
    end
    rst = 1'b0;
    sweep_from_reset("reset");
  endtask
  task automatic test_contention;
    logic [2:0][4:0] a;
    logic [2:0][31:0] d;
    logic [2:0] er;
    logic ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    a = {5'd12, 5'd11, 5'd10};
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom};
      step(3'b111, a, d);
      model_step(3'b111, a, d, er, ewe, ea, ed);
      tests++;
      if (o_rdy !== onehot(i % 3) || o_rdy !== er) begin
        fails++;
        $display("FAIL contention grant %0d: got %b required %b", i, o_rdy, onehot(i % 3));
      end
      tests++;
      if (o_we !== ewe || o_a !== ea || o_d !== ed) begin
        fails++;
        $display("FAIL contention write %0d: we=%b addr=%0d rd=%h required we=%b addr=%0d rd=%h", i, o_we, o_a, o_d, ewe, ea, ed);
      end
    end
  endtask
  task automatic test_single;
    logic [2:0][4:0] a;
    logic [2:0][31:0] d;
    logic [2:0] er;
    logic ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    a = {5'd0, 5'd5, 5'd0};
    d = {32'd0, 32'hDEADBEEF, 32'd0};
    step(3'b010, a, d);
    model_step(3'b010, a, d, er, ewe, ea, ed);
    tests++;
    if (o_rdy !== 3'b010) begin
      fails++;
      $display("FAIL single ready: got %b required 010", o_rdy);
    end
    tests++;
    if (o_we !== 1'b1 || o_a !== 5'd5 || o_d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single write: we=%b addr=%0d rd=%h required we=1 addr=5 rd=deadbeef", o_we, o_a, o_d);
    end
    step(3'b000, a, d);
    model_step(3'b000, a, d, er, ewe, ea, ed);
    tests++;
    if (o_we !== 1'b0 || rf[5] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single commit: we=%b x5=%h required we=0 x5=deadbeef", o_we, rf[5]);
    end
  endtask
  task automatic test_pointer_hold;
    logic [2:0][4:0] a;
    logic [2:0][31:0] d;
    logic [2:0] er;
    logic ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    a = {5'd7, 5'd0, 5'd8};
    d = {$urandom, $urandom, $urandom};
    step(3'b100, a, d);
    model_step(3'b100, a, d, er, ewe, ea, ed);
    tests++;
    if (o_rdy !== 3'b100 || o_we !== 1'b1 || o_a !== 5'd7) begin
      fails++;
      $display("FAIL hold first grant: ready=%b we=%b addr=%0d required ready=100 we=1 addr=7", o_rdy, o_we, o_a);
    end
    for (int i = 0; i < 3; i++) begin
      step(3'b000, a, d);
      model_step(3'b000, a, d, er, ewe, ea, ed);
      tests++;
      if (o_we !== 1'b0 || o_rdy !== 3'b000 || o_a !== ea || o_d !== ed) begin
        fails++;
        $display("FAIL hold idle %0d: we=%b ready=%b addr=%0d rd=%h required we=0 ready=000 addr=%0d rd=%h", i, o_we, o_rdy, o_a, o_d, ea, ed);
      end
    end
    step(3'b101, a, d);
    model_step(3'b101, a, d, er, ewe, ea, ed);
    tests++;
    if (o_rdy !== 3'b001 || o_we !== 1'b1 || o_a !== 5'd8 || o_d !== d[0]) begin
      fails++;
      $display("FAIL hold resume: ready=%b we=%b addr=%0d rd=%h required ready=001 we=1 addr=8 rd=%h", o_rdy, o_we, o_a, o_d, d[0]);
    end
  endtask
  task automatic test_x0_drop;
    logic [2:0][4:0] a;
    logic [2:0][31:0] d;
    logic [2:0] er;
    logic ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    a = {5'd0, 5'd9, 5'd0};
    d = {32'd0, 32'h0BADF00D, 32'h1234};
    step(3'b001, a, d);
    model_step(3'b001, a, d, er, ewe, ea, ed);
    tests++;
    if (o_rdy !== 3'b001 || o_we !== 1'b0) begin
      fails++;
      $display("FAIL x0 drop: ready=%b we=%b required ready=001 we=0", o_rdy, o_we);
    end
    step(3'b011, a, d);
    model_step(3'b011, a, d, er, ewe, ea, ed);
    tests++;
    if (o_rdy !== 3'b010 || o_we !== 1'b1 || o_a !== 5'd9) begin
      fails++;
      $display("FAIL x0 pointer advance: ready=%b we=%b addr=%0d required ready=010 we=1 addr=9", o_rdy, o_we, o_a);
    end
  endtask
  task automatic test_random;
    logic [2:0] pv;
    logic [2:0][4:0] pa;
    logic [2:0][31:0] pd;
    logic [2:0] er;
    logic ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    pv = '0;
    pa = '0;
    pd = '0;
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (!pv[r] && $urandom_range(1, 0) == 1) begin
          pv[r] = 1'b1;
          pa[r] = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
          pd[r] = $urandom;
        end
      end
      step(pv, pa, pd);
      model_step(pv, pa, pd, er, ewe, ea, ed);
      tests++;
      if (o_rdy !== er) begin
        fails++;
        $display("FAIL random grant %0d: got %b required %b (valid %b)", i, o_rdy, er, pv);
      end
      tests++;
      if (o_we !== ewe || ((ewe || hold_ok) && (o_a !== ea || o_d !== ed))) begin
        fails++;
        $display("FAIL random write %0d: we=%b addr=%0d rd=%h required we=%b addr=%0d rd=%h", i, o_we, o_a, o_d, ewe, ea, ed);
      end
      pv = pv & ~er;
    end
    step(3'b000, pa, pd);
    model_step(3'b000, pa, pd, er, ewe, ea, ed);
    for (int i = 1; i < 32; i++) begin
      tests++;
      if (rf[i] !== mrf[i]) begin
        fails++;
        $display("FAIL random contents x%0d: got %h required %h", i, rf[i], mrf[i]);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [2:0][4:0] a;
    logic [2:0][31:0] d;
    a = {5'd22, 5'd21, 5'd20};
    d = {$urandom, $urandom, $urandom};
    step(3'b111, a, d);
    #1;
    tests++;
    if (bus.req_ready === 3'b000 || bus.write_en !== 1'b1) begin
      fails++;
      $display("FAIL mid-reset precondition: ready=%b we=%b required nonzero grant and we=1", bus.req_ready, bus.write_en);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.write_en !== 1'b0 || bus.req_ready !== 3'b000 || bus.init_done !== 1'b0 || bus.addr_rd !== 5'd0 || bus.rd !== 32'd0) begin
      fails++;
      $display("FAIL mid-reset async clear: we=%b ready=%b done=%b addr=%0d rd=%h required all 0",
               bus.write_en, bus.req_ready, bus.init_done, bus.addr_rd, bus.rd);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweep_from_reset("midreset");
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    hold_ok = 1'b1;
    last_a = '0;
    last_d = '0;
    test_reset;
    test_contention;
    test_single;
    test_pointer_hold;
    test_x0_drop;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port controller for `register_file`. After reset it sequences a clear of every architectural register (x1..x(NRegs-1)) to zero. It then arbitrates the single register-file write port between `NReq` writeback requesters (ALU, load unit, mul/div) using round-robin valid/ready handshakes. It sits between the writeback stage and `register_file`'s `iWriteEn`/`iAddr_Rd`/`iRd` inputs.

## Interface
- `NRegs`, 32, number of registers in the attached `register_file`; x0 is never written.
- `NReq`, 3, number of writeback requesters (≥2).
- Widths `RegWidth` (32) and `RegAddrWidth` (5) come from `rv32_isa`.

Ports:
- `iClk`  in  1  single clock, all state on rising edge.
- `iRst`  in  1  reset, asynchronous, active-high.
- `iReqValid`  in  NReq  per-requester write request.
- `iReqAddr`  in  NReq*RegAddrWidth  packed destination addresses; requester i at bits [i*RegAddrWidth +: RegAddrWidth].
- `iReqData`  in  NReq*RegWidth  packed write data; requester i at [i*RegWidth +: RegWidth].
- `oReqReady`  out  NReq  one-hot-or-zero grant; transfer when valid&ready at a rising edge.
- `oWriteEn`  out  1  to `register_file.iWriteEn`, registered.
- `oAddr_Rd`  out  RegAddrWidth  to `register_file.iAddr_Rd`, registered.
- `oRd`  out  RegWidth  to `register_file.iRd`, registered.
- `oInitDone`  out  1  high once the clear sweep has finished; stays high until the next reset.

## Operation
- States:
  - `INIT`: entered on reset.
  - `RUN`: entered from `INIT` only; leaving `RUN` requires reset.
- `INIT` sweep:
  - Clear counter resets to 1.
  - Each rising edge registers `oWriteEn`=1, `oAddr_Rd`=counter, `oRd`=0, then increments the counter.
  - On the edge that presents address NRegs-1, the state becomes `RUN` and `oInitDone` goes to 1.
  - `oReqReady`=0 throughout `INIT`; requests are ignored, not queued.
- `RUN` arbitration:
  - Priority pointer `ptr` resets to 0.
  - Grant goes combinationally to the first valid requester scanning `ptr`, `ptr`+1, … mod NReq.
  - `oReqReady` is that grant. At most one bit is set, and none are set if no request is valid.
- Pointer update:
  - On a transfer from requester g, `ptr` ← (g+1) mod NReq.
  - With no transfer, `ptr` holds.
- Write output:
  - On a transfer, the next edge registers `oWriteEn`=1, `oAddr_Rd`=addr_g, `oRd`=data_g.
  - With no transfer, the edge registers `oWriteEn`=0; `oAddr_Rd`/`oRd` hold their last values.
- x0 requests:
  - A request to address 0 is granted and advances `ptr` like any other.
  - It is then dropped: `oWriteEn` is 0 that cycle.
- Requester rule: once `iReqValid[i]` is raised, address and data must stay stable until ready is seen. The arbiter does not check this.
- Reset mid-operation:
  - All outputs clear immediately, asynchronously, regardless of any in-flight grant.
  - The in-flight grant is lost.
  - The `INIT` sweep restarts from x1.

## Timing
- Reset values: `oWriteEn`=0, `oAddr_Rd`=0, `oRd`=0, `oInitDone`=0, `oReqReady`=0, `ptr`=0, counter=1, state=`INIT`.
- Sweep timing:
  - First edge after reset release presents x1.
  - Edge k presents x(k) for k=1..NRegs-1.
  - `oInitDone` rises at edge NRegs-1 (edge 31 for the defaults).
  - `oReqReady` may assert in the cycle after edge NRegs-1.
- Handshake: valid→ready is combinational, with zero cycles of grant latency.
- Write latency: request accepted at edge n → `oWriteEn`/`oAddr_Rd`/`oRd` valid after edge n, committed into `register_file` at edge n+1.
- Throughput: one write per cycle sustained.
- Starvation bound: a continuously valid requester is granted within NReq cycles.

## Test plan
- **Reset and sweep:**
  - Stimulus: assert `iRst` for 2 cycles, release, hold all valids high.
  - Required response: `oAddr_Rd` steps 1..31 with `oWriteEn`=1 and `oRd`=0; `oReqReady`=0 until `oInitDone`=1 at edge 31; reading every rs port afterwards returns 0.
- **Single requester:**
  - Stimulus: requester 1 sends addr 5, data 0xDEADBEEF.
  - Required response: `oReqReady`=3'b010 in the same cycle; next edge gives `oWriteEn`=1, `oAddr_Rd`=5, `oRd`=0xDEADBEEF; rs1=5 reads 0xDEADBEEF one edge later.
- **Full contention:**
  - Stimulus: all three requesters valid for 6 cycles, each carrying a distinct address.
  - Required response: grant order 0,1,2,0,1,2; no requester is granted twice before the other valid ones are served.
- **Pointer hold:**
  - Stimulus: grant to requester 2, 3 idle cycles, then requesters 0 and 2 both valid.
  - Required response: requester 0 is granted first (`ptr`=0); idle cycles show `oWriteEn`=0.
- **x0 drop:**
  - Stimulus: requester 0 sends addr 0, data 0x1234.
  - Required response: ready=1; `oWriteEn` stays 0; `ptr` advances to 1; rs1=0 still reads 0.
- **Reset mid-run:**
  - Stimulus: assert `iRst` asynchronously between edges while a grant is active.
  - Required response: `oWriteEn`, `oReqReady` and `oInitDone` go to 0 immediately, with no write committed; the sweep restarts at x1 after release, and previously written registers read 0 after it completes.
